fpga: RTL and testbench
=======================

Name: fpga

Overview:
- Top-level 16-station shared serial bus.
- Each station n (1..16) presents a 64-bit payload, a 4-bit destination address and a 4-bit CRC.
- Stations request the bus through one bit of mod.
- A round-robin arbiter grants one station at a time; the winner's frame is serialized MSB-first onto the single-bit bus_show line.

Parameters:
- N_ST, 16, number of stations (fixed; one port group per station)
- DATA_W, 64, payload width
- ADDR_W, 4, address field width
- CRC_W, 4, CRC field width
- FRAME_W, 77, frame length = 1 + ADDR_W + ADDR_W + DATA_W + CRC_W

Ports:
- clock  input  1  system clock, rising-edge
- reset_n  input  1  synchronous active-low reset
- mod  input  16  bit n-1 = transmit request of station n (level)
- Data1..Data16  input  64 each  station payload
- receiverAddr1..receiverAddr16  input  4 each  destination address
- CRC1..CRC16  input  4 each  frame check field
- bus_show  output  1  serial bus line, registered

Interface decision (already decided):
- One clock (clock); reset (reset_n) is synchronous and active-low.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - state=IDLE, bus_show=0, bit counter=0.
  - Round-robin pointer set so station 1 has highest priority.
  - Applies mid-frame too; the partial frame is abandoned.
- States: IDLE, SEND.
- IDLE:
  - bus_show=0.
  - On a rising edge with mod!=0, grant the first set bit at or after the pointer, scanning upward with wrap 16->1.
  - Latch that station's frame into a 77-bit shift register.
  - bus_show=1 (start bit) on the same edge; counter=76; go to SEND.
  - mod==0: remain IDLE.
- Frame layout, MSB first:
  - start bit 1
  - sender address = n-1 (4b)
  - receiverAddr_n (4b)
  - Data_n[63:0]
  - CRC_n[3:0]
- SEND:
  - Each edge shifts out the next bit and decrements the counter.
  - After the last CRC bit (76 edges after the start bit), the next edge drives bus_show=0 and returns to IDLE.
  - The pointer moves to the winner+1, wrapping 16->1.
- Latency: start bit visible 1 edge after the request is sampled; frame occupies 77 cycles. Minimum idle gap between frames is 1 cycle (next start bit 78 edges after the previous one).
- Inputs are sampled only at grant:
  - Changes to Data/addr/CRC/mod during SEND do not affect the current frame.
  - Deasserting mod mid-frame does not truncate the frame.
- A station holding mod high keeps being re-granted, interleaved fairly with other requesters.
- No acknowledgement path; the requester owns mod deassertion.

Optional Feature:
- Macro FPGA_CRC_GEN_EN.
- Defined: the CRC field is computed internally as CRC-4, poly x^4+x+1, init 0, over the 72 bits {sender addr, receiverAddr, Data}, MSB first. The CRCn inputs are ignored.
- Undefined: CRCn inputs are transmitted verbatim.
- All other timing is identical in both builds.

Decomposition:
- Package fpga_pkg holds:
  - widths (DATA_W, ADDR_W, CRC_W, FRAME_W)
  - state enum (IDLE, SEND)
  - CRC polynomial constant
- One sub-module, fpga_rr_arbiter: 16-bit request vector plus pointer in, one-hot/index grant out, combinational.
- Frame assembly and the shifter stay in the top.

Test Plan:
- Reset held 3 cycles with mod=16'h0001 -> bus_show=0 throughout, no frame starts.
- Single station, no macro:
  - Stimulus: mod=1, Data1=1, receiverAddr1=1, CRC1=1, release reset.
  - Response: bits 1,0000,0001, 63 zeros, 1, 0001.
  - Then bus_show=0 for 1 cycle, then the frame repeats while mod stays 1.
- Contention:
  - Stimulus: mod=16'h8003.
  - Response: frame order station1 (sender 0000), station2 (0001), station16 (1111), station1; each 77 bits, 1-cycle gap.
- Mid-frame change: change Data1 and drop mod at bit 20 -> the current frame completes with the latched Data1, then bus stays 0.
- Reset mid-frame: reset_n=0 at bit 40 -> bus_show=0 next edge; after release the frame restarts from the start bit, station 1 first.
- Macro FPGA_CRC_GEN_EN defined:
  - Stimulus: Data1=1, receiverAddr1=1, CRC1=4'hF.
  - Response: transmitted CRC field equals the CRC-4 (x^4+x+1) of the 72-bit header+data, not 1111.

Source files
------------

// File: rtl/fpga_pkg.sv
// Shared widths, FSM encoding and CRC-4 helper for the 16-station serial bus.
// The CRC helper is only referenced when FPGA_CRC_GEN_EN is defined.
package fpga_pkg;

    localparam int N_ST    = 16;
    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 4;
    localparam int CRC_W   = 4;
    localparam int HDR_W   = ADDR_W + ADDR_W + DATA_W;
    localparam int FRAME_W = 1 + HDR_W + CRC_W;
    localparam int CNT_W   = 7;

    // x^4 + x + 1 with the implicit x^4 term dropped
    localparam logic [CRC_W-1:0] CRC_POLY = 4'h3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [CRC_W-1:0] crc4_calc(input logic [HDR_W-1:0] msg);
        logic [CRC_W-1:0] crc;
        logic             fb;
        crc = {CRC_W{1'b0}};
        for (int i = HDR_W - 1; i >= 0; i--) begin
            fb  = crc[CRC_W-1] ^ msg[i];
            crc = {crc[CRC_W-2:0], 1'b0};
            if (fb) begin
                crc = crc ^ CRC_POLY;
            end else begin
                crc = crc;
            end
        end
        return crc;
    endfunction

endpackage

// File: rtl/fpga_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after the pointer,
// scanning upward with wrap from the last station back to the first.
module fpga_rr_arbiter
    import fpga_pkg::*;
(
    input  logic [N_ST-1:0] i_req,
    input  logic [3:0]      i_ptr,
    output logic            o_valid,
    output logic [3:0]      o_idx
);

    logic [3:0] w_pos;

    // Priority scan starting at the pointer; the 4-bit add provides the wrap.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = 4'd0;
        w_pos   = 4'd0;
        for (int i = 0; i < N_ST; i++) begin
            w_pos = i_ptr + 4'(i);
            if (!o_valid && i_req[w_pos]) begin
                o_valid = 1'b1;
                o_idx   = w_pos;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/fpga.sv
// 16-station shared serial bus: round-robin grant, 77-bit frame shifted MSB-first.
// Build option FPGA_CRC_GEN_EN replaces the CRCn inputs with an internal CRC-4.
module fpga
    import fpga_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic [N_ST-1:0]     mod,
    input  logic [DATA_W-1:0]   Data1, Data2, Data3, Data4, Data5, Data6, Data7, Data8,
    input  logic [DATA_W-1:0]   Data9, Data10, Data11, Data12, Data13, Data14, Data15, Data16,
    input  logic [ADDR_W-1:0]   receiverAddr1, receiverAddr2, receiverAddr3, receiverAddr4,
    input  logic [ADDR_W-1:0]   receiverAddr5, receiverAddr6, receiverAddr7, receiverAddr8,
    input  logic [ADDR_W-1:0]   receiverAddr9, receiverAddr10, receiverAddr11, receiverAddr12,
    input  logic [ADDR_W-1:0]   receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16,
    input  logic [CRC_W-1:0]    CRC1, CRC2, CRC3, CRC4, CRC5, CRC6, CRC7, CRC8,
    input  logic [CRC_W-1:0]    CRC9, CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16,
    output logic                bus_show
);

    logic [DATA_W-1:0]  w_data   [N_ST];
    logic [ADDR_W-1:0]  w_addr   [N_ST];
    logic [CRC_W-1:0]   w_crc_in [N_ST];

    assign w_data   = '{Data1, Data2, Data3, Data4, Data5, Data6, Data7, Data8,
                        Data9, Data10, Data11, Data12, Data13, Data14, Data15, Data16};
    assign w_addr   = '{receiverAddr1, receiverAddr2, receiverAddr3, receiverAddr4,
                        receiverAddr5, receiverAddr6, receiverAddr7, receiverAddr8,
                        receiverAddr9, receiverAddr10, receiverAddr11, receiverAddr12,
                        receiverAddr13, receiverAddr14, receiverAddr15, receiverAddr16};
    assign w_crc_in = '{CRC1, CRC2, CRC3, CRC4, CRC5, CRC6, CRC7, CRC8,
                        CRC9, CRC10, CRC11, CRC12, CRC13, CRC14, CRC15, CRC16};

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_bus;
    logic                w_bus_nxt;
    logic [FRAME_W-1:0]  r_shift;
    logic [FRAME_W-1:0]  w_shift_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [3:0]          r_ptr;
    logic [3:0]          w_ptr_nxt;
    logic                w_gnt_valid;
    logic [3:0]          w_gnt_idx;
    logic [HDR_W-1:0]    w_hdr;
    logic [CRC_W-1:0]    w_crc;
    logic [FRAME_W-1:0]  w_frame;

    fpga_rr_arbiter u_arb (
        .i_req   (mod),
        .i_ptr   (r_ptr),
        .o_valid (w_gnt_valid),
        .o_idx   (w_gnt_idx)
    );

    // Winner's frame: start bit, sender address (index), receiver, payload, CRC.
    always_comb begin
        w_hdr = {w_gnt_idx, w_addr[w_gnt_idx], w_data[w_gnt_idx]};
`ifdef FPGA_CRC_GEN_EN
        w_crc = crc4_calc(w_hdr);
`else
        w_crc = w_crc_in[w_gnt_idx];
`endif
        w_frame = {1'b1, w_hdr, w_crc};
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_gnt_valid ? SEND : IDLE;
            SEND:    w_state_nxt = (r_cnt == {CNT_W{1'b0}}) ? IDLE : SEND;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath next values; the start bit goes out on the grant edge, so the
    // shifter holds the remaining 76 bits left-aligned.
    always_comb begin
        w_bus_nxt   = 1'b0;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_bus_nxt   = 1'b1;
                    w_shift_nxt = {w_frame[FRAME_W-2:0], 1'b0};
                    w_cnt_nxt   = CNT_W'(FRAME_W - 1);
                    w_ptr_nxt   = w_gnt_idx + 4'd1;
                end else begin
                    w_bus_nxt   = 1'b0;
                end
            end
            SEND: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_bus_nxt   = 1'b0;
                end else begin
                    w_bus_nxt   = r_shift[FRAME_W-1];
                    w_shift_nxt = {r_shift[FRAME_W-2:0], 1'b0};
                    w_cnt_nxt   = r_cnt - 7'd1;
                end
            end
            default: w_bus_nxt = 1'b0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_bus   <= 1'b0;
            r_shift <= {FRAME_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_ptr   <= 4'd0;
        end else begin
            r_bus   <= w_bus_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign bus_show = r_bus;

endmodule

// File: tb/tb_fpga.sv
// Scoreboard bench for fpga: expected bus bits are queued as stimulus is applied
// and compared each cycle on the falling edge.
module tb_fpga;

    logic         clock;
    logic         reset_n;
    logic [15:0]  mod;
    logic [63:0]  r_data [16];
    logic [3:0]   r_addr [16];
    logic [3:0]   r_crc  [16];
    logic         bus_show;

    logic         sb_q [$];
    int           n_checks;
    int           n_fail;
    logic [76:0]  saved_frame;

    fpga dut (
        .clock(clock), .reset_n(reset_n), .mod(mod),
        .Data1(r_data[0]),   .Data2(r_data[1]),   .Data3(r_data[2]),   .Data4(r_data[3]),
        .Data5(r_data[4]),   .Data6(r_data[5]),   .Data7(r_data[6]),   .Data8(r_data[7]),
        .Data9(r_data[8]),   .Data10(r_data[9]),  .Data11(r_data[10]), .Data12(r_data[11]),
        .Data13(r_data[12]), .Data14(r_data[13]), .Data15(r_data[14]), .Data16(r_data[15]),
        .receiverAddr1(r_addr[0]),   .receiverAddr2(r_addr[1]),   .receiverAddr3(r_addr[2]),
        .receiverAddr4(r_addr[3]),   .receiverAddr5(r_addr[4]),   .receiverAddr6(r_addr[5]),
        .receiverAddr7(r_addr[6]),   .receiverAddr8(r_addr[7]),   .receiverAddr9(r_addr[8]),
        .receiverAddr10(r_addr[9]),  .receiverAddr11(r_addr[10]), .receiverAddr12(r_addr[11]),
        .receiverAddr13(r_addr[12]), .receiverAddr14(r_addr[13]), .receiverAddr15(r_addr[14]),
        .receiverAddr16(r_addr[15]),
        .CRC1(r_crc[0]),   .CRC2(r_crc[1]),   .CRC3(r_crc[2]),   .CRC4(r_crc[3]),
        .CRC5(r_crc[4]),   .CRC6(r_crc[5]),   .CRC7(r_crc[6]),   .CRC8(r_crc[7]),
        .CRC9(r_crc[8]),   .CRC10(r_crc[9]),  .CRC11(r_crc[10]), .CRC12(r_crc[11]),
        .CRC13(r_crc[12]), .CRC14(r_crc[13]), .CRC15(r_crc[14]), .CRC16(r_crc[15]),
        .bus_show(bus_show)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference CRC by polynomial long division of {msg, 0000} by 10011.
    function automatic logic [3:0] ref_crc(input logic [71:0] m);
        logic [75:0] r;
        r = {m, 4'b0000};
        for (int i = 75; i >= 4; i--) begin
            if (r[i]) r[i-:5] = r[i-:5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    function automatic logic [76:0] build_frame(input int s);
        logic [71:0] hdr;
        logic [3:0]  c;
        hdr = {4'(s), r_addr[s], r_data[s]};
`ifdef FPGA_CRC_GEN_EN
        c = ref_crc(hdr);
`else
        c = r_crc[s];
`endif
        return {1'b1, hdr, c};
    endfunction

    task automatic push_bits(input logic [76:0] f, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) sb_q.push_back(f[i]);
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(1'b0);
    endtask

    task automatic push_frame(input int s);
        push_bits(build_frame(s), 76, 0);
    endtask

    // Consume the scoreboard one cycle per entry; length is bounded by the queue.
    task automatic drain(input string tag);
        logic exp_bit;
        while (sb_q.size() > 0) begin
            @(posedge clock);
            @(negedge clock);
            exp_bit = sb_q.pop_front();
            check_eq(tag, {63'd0, bus_show}, {63'd0, exp_bit});
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 16; i++) begin
            r_data[i] = 64'h0;
            r_addr[i] = 4'h0;
            r_crc[i]  = 4'h0;
        end
        r_data[0]  = 64'h1;                    r_addr[0]  = 4'h1; r_crc[0]  = 4'h1;
        r_data[1]  = 64'hA5A5_0000_1234_5678;  r_addr[1]  = 4'h2; r_crc[1]  = 4'h6;
        r_data[15] = 64'hFFFF_0000_DEAD_BEEF;  r_addr[15] = 4'h9; r_crc[15] = 4'hC;
`ifdef FPGA_CRC_GEN_EN
        r_crc[0] = 4'hF;
`endif
        reset_n = 1'b0;
        mod     = 16'h0001;

        push_zeros(3);
        drain("reset_hold");

        reset_n = 1'b1;
        push_frame(0);
        push_zeros(1);
        push_frame(0);
        push_zeros(1);
        drain("single_st1");

        reset_n = 1'b0;
        mod     = 16'h8003;
        push_zeros(2);
        drain("reset_before_contention");
        reset_n = 1'b1;
        push_frame(0);  push_zeros(1);
        push_frame(1);  push_zeros(1);
        push_frame(15); push_zeros(1);
        push_frame(0);
        drain("contention");

        reset_n = 1'b0;
        mod     = 16'h0001;
        push_zeros(2);
        drain("reset_before_midchange");
        reset_n = 1'b1;
        saved_frame = build_frame(0);
        push_bits(saved_frame, 76, 57);
        drain("midchange_head");
        r_data[0] = 64'hCAFE_F00D_0BAD_BEEF;
        r_addr[0] = 4'h7;
        mod       = 16'h0000;
        push_bits(saved_frame, 56, 0);
        push_zeros(5);
        drain("midchange_tail");

        mod = 16'h0001;
        saved_frame = build_frame(0);
        push_bits(saved_frame, 76, 37);
        drain("pre_reset_frame");
        reset_n = 1'b0;
        push_zeros(2);
        drain("reset_midframe");
        reset_n = 1'b1;
        push_frame(0);
        drain("restart_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
